des_key_schedule_seq: RTL

Sequential DES key-schedule engine. Accepts a 64-bit key and a mode, then streams the 16 round subkeys (48 b each), one per accepted handshake. Encrypt order is K1..K16; decrypt order is K16..K1. Applies FIPS 46-3 PC-1 on start, per-round C/D rotation, and PC-2 on output. Feeds the round datapath of the iterative DES core through a valid/ready stream with backpressure.

---
 rtl/des_key_schedule_seq.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/des_key_schedule_seq.sv
// DES key-schedule engine: PC-1 on start, per-round C/D rotation, PC-2 on
// output, streaming 16 subkeys over a valid/ready handshake in encrypt
// (K1..K16) or decrypt (K16..K1) order.
//
// state | meaning
// IDLE  | waiting for start; C/D and round counter hold their last values
// RUN   | subkey_valid high, PC-2(C,D) presented, advances on handshake
// ERR   | one-cycle parity rejection, pulses parity_err
module des_key_schedule_seq #(
  parameter logic [15:0] SHIFT_MASK   = 16'h7EFC,
  parameter bit          PARITY_CHECK = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] key,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  round,
  output logic        busy,
  output logic        done,
  output logic        parity_err
);

  typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

  // Table entries are DES bit numbers, bit 1 = MSB of the source word.
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1_TAB[i]];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2_TAB[i]];
    return r;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] v, input logic two);
    return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] v, input logic two);
    return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
  endfunction

  state_t      state_q, state_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [4:0]  j_q, j_d;
  logic        dec_q, dec_d;
  logic        done_q, done_d;
  logic [55:0] cd0;
  logic        parity_ok;
  logic [3:0]  enc_idx, dec_idx;
  logic [4:0]  dec_tmp;
  logic [3:0]  rnd_enc, rnd_dec;
  logic [4:0]  jm1;

  assign cd0 = pc1(key);

  // Odd parity per key byte; only enforced when the check is enabled.
  always_comb begin
    parity_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (PARITY_CHECK && !(^key[8*i +: 8])) parity_ok = 1'b0;
    end
  end

  // Rotation amount indices: encrypt step j -> shift(j+1), decrypt -> shift(17-j).
  always_comb begin
    enc_idx = j_q[3:0];
    dec_tmp = 5'd16 - j_q;
    dec_idx = dec_tmp[3:0];
    jm1     = j_q - 5'd1;
    rnd_enc = jm1[3:0];
    rnd_dec = dec_tmp[3:0];
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    j_d     = j_q;
    dec_d   = dec_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (parity_ok) begin
            dec_d   = decrypt;
            j_d     = 5'd1;
            state_d = RUN;
            if (decrypt) begin
              c_d = cd0[55:28];
              d_d = cd0[27:0];
            end else begin
              c_d = rotl(cd0[55:28], SHIFT_MASK[0]);
              d_d = rotl(cd0[27:0],  SHIFT_MASK[0]);
            end
          end else begin
            state_d = ERR;
          end
        end
      end
      RUN: begin
        if (subkey_ready) begin
          if (j_q == 5'd16) begin
            state_d = IDLE;
            done_d  = 1'b1;
            j_d     = 5'd0;
          end else begin
            j_d = j_q + 5'd1;
            if (dec_q) begin
              c_d = rotr(c_q, SHIFT_MASK[dec_idx]);
              d_d = rotr(d_q, SHIFT_MASK[dec_idx]);
            end else begin
              c_d = rotl(c_q, SHIFT_MASK[enc_idx]);
              d_d = rotl(d_q, SHIFT_MASK[enc_idx]);
            end
          end
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      j_q     <= '0;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      j_q     <= j_d;
      dec_q   <= dec_d;
      done_q  <= done_d;
    end
  end

  assign subkey_valid = (state_q == RUN);
  assign busy         = (state_q == RUN);
  assign parity_err   = (state_q == ERR);
  assign done         = done_q;
  assign subkey       = subkey_valid ? pc2({c_q, d_q}) : 48'd0;
  assign round        = subkey_valid ? (dec_q ? rnd_dec : rnd_enc) : 4'd0;

endmodule
